// File: rtl/ben_pkg.sv
// Shared types, NZP encodings and classification helper for the
// multi-context branch-enable unit.
package ben_pkg;

   typedef logic [2:0] nzp_t;

   localparam nzp_t NZP_N = 3'b100;
   localparam nzp_t NZP_Z = 3'b010;
   localparam nzp_t NZP_P = 3'b001;
   localparam nzp_t NZP_0 = 3'b000;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } br_state_t;

   // Width-independent core: callers reduce the bus word to its flags.
   function automatic nzp_t nzp_classify(
      input logic is_neg,
      input logic is_zero,
      input logic unsigned_mode
   );
      nzp_t r;
      r = NZP_P;
      if (is_zero) begin
         r = NZP_Z;
      end else if (is_neg && !unsigned_mode) begin
         r = NZP_N;
      end
      return r;
   endfunction

endpackage

// File: rtl/ben_unit_mc_classifier.sv
// Combinational NZP classifier for one DATA_W-bit bus word.
// Shared by the condition-code load path and the request bypass path.
module nzp_classifier
   import ben_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] din_i,
   input  logic              unsigned_i,
   output nzp_t              nzp_o
);

   logic is_zero;
   logic is_neg;

   assign is_zero = (din_i == '0);
   assign is_neg  = din_i[DATA_W-1];
   assign nzp_o   = nzp_classify(is_neg, is_zero, unsigned_i);

endmodule

// File: rtl/ben_unit_mc.sv
// Multi-context branch-enable unit: per-context NZP registers, legacy
// BEN register and a valid/ready branch-resolve port with taken counter.
module ben_unit_mc
   import ben_pkg::*;
#(
   parameter  int DATA_W  = 16,
   parameter  int NUM_CTX = 4,
   parameter  int CNT_W   = 16,
   parameter  int BYPASS  = 1,
   localparam int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] DIN,
   input  logic              LD_CC,
   input  logic [CTX_W-1:0]  CC_CTX,
   input  logic              UNSIGNED,
   input  logic [2:0]        IR_Slice,
   input  logic              LD_BEN,
   input  logic [CTX_W-1:0]  BEN_CTX,
   output logic              BEN_OUT,
   output logic [2:0]        NZP_OUT,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic [CTX_W-1:0]  REQ_CTX,
   input  logic [2:0]        REQ_MASK,
   output logic              RESP_VALID,
   input  logic              RESP_READY,
   output logic              RESP_TAKEN,
   input  logic              CLR_CNT,
   output logic [CNT_W-1:0]  TAKEN_CNT
);

   nzp_t        nzp_q [NUM_CTX];
   nzp_t        din_nzp;
   nzp_t        ben_nzp;
   nzp_t        req_nzp;
   nzp_t        nzp_eff;
   logic        cc_ok;
   logic        req_ok;
   logic        cc_hit;
   logic        req_taken;
   logic        accept;
   logic        ben_q;
   logic        taken_q;
   logic        taken_d;
   br_state_t   state_q;
   br_state_t   state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   nzp_classifier #(
      .DATA_W (DATA_W)
   ) u_cls (
      .din_i      (DIN),
      .unsigned_i (UNSIGNED),
      .nzp_o      (din_nzp)
   );

   assign cc_ok  = (int'(CC_CTX) < NUM_CTX);
   assign req_ok = (int'(REQ_CTX) < NUM_CTX);
   assign cc_hit = LD_CC & cc_ok;

   // Out-of-range contexts read back as 000.
   always_comb begin
      ben_nzp = NZP_0;
      req_nzp = NZP_0;
      for (int i = 0; i < NUM_CTX; i++) begin
         if (BEN_CTX == CTX_W'(i)) ben_nzp = nzp_q[i];
         if (REQ_CTX == CTX_W'(i)) req_nzp = nzp_q[i];
      end
   end

   always_comb begin
      nzp_eff = req_nzp;
      if ((BYPASS != 0) && cc_hit && (CC_CTX == REQ_CTX)) begin
         nzp_eff = din_nzp;
      end
   end

   assign req_taken = req_ok & (|(nzp_eff & REQ_MASK));
   assign NZP_OUT   = ben_nzp;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_CTX; i++) nzp_q[i] <= NZP_0;
      end else begin
         for (int i = 0; i < NUM_CTX; i++) begin
            if (cc_hit && (CC_CTX == CTX_W'(i))) nzp_q[i] <= din_nzp;
         end
      end
   end

   // Legacy path sees the pre-edge NZP, as in the original datapath.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ben_q <= 1'b0;
      end else if (LD_BEN) begin
         ben_q <= |(ben_nzp & IR_Slice);
      end
   end

   assign BEN_OUT = ben_q;

   always_comb begin
      state_d   = state_q;
      taken_d   = taken_q;
      REQ_READY = 1'b0;
      unique case (state_q)
         IDLE: REQ_READY = 1'b1;
         RESP: REQ_READY = RESP_READY;
         default: REQ_READY = 1'b0;
      endcase
      accept = REQ_VALID & REQ_READY;
      if (accept) begin
         state_d = RESP;
         taken_d = req_taken;
      end else if (state_q == RESP && RESP_READY) begin
         state_d = IDLE;
         taken_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         taken_q <= taken_d;
      end
   end

   assign RESP_VALID = (state_q == RESP);
   assign RESP_TAKEN = taken_q;

   always_comb begin
      cnt_d = cnt_q;
      if (CLR_CNT) begin
         cnt_d = '0;
      end else if (RESP_VALID && RESP_READY && RESP_TAKEN
                   && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign TAKEN_CNT = cnt_q;

endmodule

// File: tb/tb_ben_unit_mc.sv
// Directed bench: instance A (BYPASS=1, 16-bit counter) and instance B
// (BYPASS=0, 2-bit counter) share all inputs.
module tb_ben_unit_mc;

   logic        Clk;
   logic        Reset;
   logic [15:0] DIN;
   logic        LD_CC;
   logic [1:0]  CC_CTX;
   logic        UNSIGNED;
   logic [2:0]  IR_Slice;
   logic        LD_BEN;
   logic [1:0]  BEN_CTX;
   logic        REQ_VALID;
   logic [1:0]  REQ_CTX;
   logic [2:0]  REQ_MASK;
   logic        RESP_READY;
   logic        CLR_CNT;

   logic        ben_a, rdy_a, rv_a, rt_a;
   logic [2:0]  nzp_a;
   logic [15:0] cnt_a;
   logic        ben_b, rdy_b, rv_b, rt_b;
   logic [2:0]  nzp_b;
   logic [1:0]  cnt_b;

   int total = 0;
   int bad   = 0;

   ben_unit_mc #(
      .DATA_W (16), .NUM_CTX (4), .CNT_W (16), .BYPASS (1)
   ) u_a (
      .Clk (Clk), .Reset (Reset), .DIN (DIN), .LD_CC (LD_CC),
      .CC_CTX (CC_CTX), .UNSIGNED (UNSIGNED), .IR_Slice (IR_Slice),
      .LD_BEN (LD_BEN), .BEN_CTX (BEN_CTX), .BEN_OUT (ben_a),
      .NZP_OUT (nzp_a), .REQ_VALID (REQ_VALID), .REQ_READY (rdy_a),
      .REQ_CTX (REQ_CTX), .REQ_MASK (REQ_MASK), .RESP_VALID (rv_a),
      .RESP_READY (RESP_READY), .RESP_TAKEN (rt_a),
      .CLR_CNT (CLR_CNT), .TAKEN_CNT (cnt_a)
   );

   ben_unit_mc #(
      .DATA_W (16), .NUM_CTX (4), .CNT_W (2), .BYPASS (0)
   ) u_b (
      .Clk (Clk), .Reset (Reset), .DIN (DIN), .LD_CC (LD_CC),
      .CC_CTX (CC_CTX), .UNSIGNED (UNSIGNED), .IR_Slice (IR_Slice),
      .LD_BEN (LD_BEN), .BEN_CTX (BEN_CTX), .BEN_OUT (ben_b),
      .NZP_OUT (nzp_b), .REQ_VALID (REQ_VALID), .REQ_READY (rdy_b),
      .REQ_CTX (REQ_CTX), .REQ_MASK (REQ_MASK), .RESP_VALID (rv_b),
      .RESP_READY (RESP_READY), .RESP_TAKEN (rt_b),
      .CLR_CNT (CLR_CNT), .TAKEN_CNT (cnt_b)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   logic [1:0] rq_ctx [5];
   logic [2:0] rq_msk [5];
   logic       rq_tkn [5];
   logic [2:0] exp_nzp [4];

   initial begin
      rq_ctx = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
      rq_msk = '{3'b100, 3'b100, 3'b001, 3'b000, 3'b111};
      rq_tkn = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_nzp = '{3'b100, 3'b010, 3'b001, 3'b001};

      Reset = 1'b0; DIN = '0; LD_CC = 0; CC_CTX = '0; UNSIGNED = 0;
      IR_Slice = '0; LD_BEN = 0; BEN_CTX = '0; REQ_VALID = 0;
      REQ_CTX = '0; REQ_MASK = '0; RESP_READY = 0; CLR_CNT = 0;
      #12;
      chk("rst_ben", ben_a, 0);
      chk("rst_rv", rv_a, 0);
      chk("rst_rt", rt_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_rdy", rdy_a, 1);
      Reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         BEN_CTX = 2'(i);
         #1;
         chk($sformatf("rst_nzp%0d", i), nzp_a, 0);
      end

      // Signed and unsigned classification loads
      LD_CC = 1; UNSIGNED = 0;
      CC_CTX = 2'd0; DIN = 16'h8000; step();
      CC_CTX = 2'd1; DIN = 16'h0000; step();
      CC_CTX = 2'd2; DIN = 16'h0005; step();
      CC_CTX = 2'd3; DIN = 16'h8000; UNSIGNED = 1; step();
      LD_CC = 0; UNSIGNED = 0;
      for (int i = 0; i < 4; i++) begin
         BEN_CTX = 2'(i);
         #1;
         chk($sformatf("nzp_a%0d", i), nzp_a, exp_nzp[i]);
         chk($sformatf("nzp_b%0d", i), nzp_b, exp_nzp[i]);
      end

      // Legacy BEN
      BEN_CTX = 2'd1; IR_Slice = 3'b010; LD_BEN = 1; step();
      chk("ben_set", ben_a, 1);
      IR_Slice = 3'b101; step();
      chk("ben_clr", ben_a, 0);
      IR_Slice = 3'b010; LD_BEN = 0; step();
      chk("ben_hold", ben_a, 0);

      // Stalled response
      REQ_VALID = 1; REQ_CTX = 2'd0; REQ_MASK = 3'b100; RESP_READY = 0;
      step();
      REQ_VALID = 0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stall_rv%0d", i), rv_a, 1);
         chk($sformatf("stall_rt%0d", i), rt_a, 1);
         chk($sformatf("stall_rdy%0d", i), rdy_a, 0);
         step();
      end
      RESP_READY = 1;
      #1;
      chk("drain_rdy", rdy_a, 1);
      step();
      chk("drain_cnt", cnt_a, 1);
      chk("drain_rv", rv_a, 0);

      // Back-to-back, one response per cycle
      for (int i = 0; i < 5; i++) begin
         REQ_VALID = 1; REQ_CTX = rq_ctx[i]; REQ_MASK = rq_msk[i];
         #1;
         chk($sformatf("b2b_rdy%0d", i), rdy_a, 1);
         step();
         chk($sformatf("b2b_rv%0d", i), rv_a, 1);
         chk($sformatf("b2b_rt%0d", i), rt_a, rq_tkn[i]);
      end
      REQ_VALID = 0;
      step();
      chk("b2b_idle", rv_a, 0);
      chk("b2b_cnt_a", cnt_a, 4);
      chk("b2b_cnt_b", cnt_b, 3);

      // Same-cycle CC write and request
      RESP_READY = 0;
      LD_CC = 1; CC_CTX = 2'd2; DIN = 16'h0000; UNSIGNED = 0;
      REQ_VALID = 1; REQ_CTX = 2'd2; REQ_MASK = 3'b010;
      step();
      LD_CC = 0; REQ_VALID = 0;
      chk("byp_rv_a", rv_a, 1);
      chk("byp_rt_a", rt_a, 1);
      chk("byp_rv_b", rv_b, 1);
      chk("byp_rt_b", rt_b, 0);
      BEN_CTX = 2'd2;
      #1;
      chk("byp_nzp_a", nzp_a, 3'b010);
      chk("byp_nzp_b", nzp_b, 3'b010);
      RESP_READY = 1;
      step();
      chk("byp_cnt_a", cnt_a, 5);
      chk("byp_cnt_b", cnt_b, 3);

      // Saturation and clear priority
      CLR_CNT = 1; step(); CLR_CNT = 0;
      chk("clr_a", cnt_a, 0);
      chk("clr_b", cnt_b, 0);
      REQ_VALID = 1; REQ_CTX = 2'd0; REQ_MASK = 3'b100;
      for (int i = 0; i < 5; i++) step();
      REQ_VALID = 0;
      step();
      chk("sat_a", cnt_a, 5);
      chk("sat_b", cnt_b, 3);
      REQ_VALID = 1; step(); REQ_VALID = 0;
      chk("clr_pend_rt", rt_a, 1);
      CLR_CNT = 1; step(); CLR_CNT = 0;
      chk("clr_pri_a", cnt_a, 0);
      chk("clr_pri_b", cnt_b, 0);

      // Async reset mid-response
      RESP_READY = 0; REQ_VALID = 1; step(); REQ_VALID = 0;
      chk("pre_rst_rv", rv_a, 1);
      #2;
      Reset = 1'b0;
      #1;
      chk("arst_rv_a", rv_a, 0);
      chk("arst_rv_b", rv_b, 0);
      chk("arst_rt_a", rt_a, 0);
      chk("arst_rdy_a", rdy_a, 1);
      chk("arst_nzp_a", nzp_a, 0);
      #5;
      Reset = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
